l15_mem_responder: RTL

//  L1.5-side responder for the core's wt_cache_pkg L15 request/return interface: accepts l15_req_t

---
 rtl/l15_mem_responder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/l15_mem_responder.sv
// L1.5 stand-in: accepts one L15 request at a time, services it from a local 64-bit-word
// memory and returns the response packet after a programmable latency.
package l15_mem_pkg;
    typedef enum logic [4:0] {
        LOAD_RQ   = 5'b00000,
        STORE_RQ  = 5'b00001,
        ATOMIC_RQ = 5'b00110,
        IMISS_RQ  = 5'b10000
    } l15_reqtypes_t;

    typedef enum logic [3:0] {
        L15_LOAD_RET   = 4'b0000,
        L15_IFILL_RET  = 4'b0001,
        L15_ATOMIC_RET = 4'b0011,
        L15_ST_ACK     = 4'b0100
    } l15_rtrntypes_t;

    typedef struct packed {
        logic          l15_val;
        logic          l15_req_ack;
        l15_reqtypes_t l15_rqtype;
        logic          l15_nc;
        logic [2:0]    l15_size;
        logic [1:0]    l15_threadid;
        logic [39:0]   l15_address;
        logic [63:0]   l15_data;
    } l15_req_t;

    typedef struct packed {
        logic           l15_ack;
        logic           l15_header_ack;
        logic           l15_val;
        l15_rtrntypes_t l15_returntype;
        logic           l15_l2miss;
        logic [1:0]     l15_error;
        logic           l15_noncacheable;
        logic           l15_atomic;
        logic [1:0]     l15_threadid;
        logic           l15_prefetch;
        logic           l15_f4b;
        logic [63:0]    l15_data_0;
        logic [63:0]    l15_data_1;
        logic [63:0]    l15_data_2;
        logic [63:0]    l15_data_3;
        logic           l15_inval_icache_all_way;
        logic           l15_inval_dcache_all_way;
        logic [15:4]    l15_inval_address_15_4;
        logic           l15_cross_invalidate;
        logic [1:0]     l15_cross_invalidate_way;
        logic           l15_inval_dcache_inval;
        logic           l15_inval_icache_inval;
        logic [1:0]     l15_inval_way;
        logic           l15_blockinitstore;
    } l15_rtrn_t;
endpackage

// state | meaning
// IDLE  | ready; a valid request is acked and serviced this cycle
// WAIT  | latency countdown, new requests ignored
// RESP  | return packet valid, held until the core's req_ack
module l15_mem_responder
    import l15_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [39:0] BASE_ADDR    = 40'h8000_0000,
    parameter int unsigned RESP_LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        reset_l,
    input  l15_req_t    l15_req_i,
    output l15_rtrn_t   l15_rtrn_o,
    output logic        busy_o,
    output logic [31:0] req_cnt_o
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [7:0]     lat_q, lat_d;
    logic           accept;
    logic [39:0]    offset;
    logic           in_range, aligned, do_write;
    logic [AW-1:0]  idx;
    logic [3:0]     nbytes;
    logic [7:0]     byte_en;
    l15_rtrntypes_t rtype_d, rtype_q;
    logic [1:0]     err_d, err_q;
    logic           atomic_d, atomic_q, nc_q;
    logic [1:0]     tid_q;
    logic [63:0]    d0_d, d1_d, d2_d, d3_d, d0_q, d1_q, d2_q, d3_q;
    logic [63:0]    mem [MEM_WORDS];

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (l15_req_i.l15_val && reset_l) begin
                    accept = 1'b1;
                    if (RESP_LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        lat_d   = 8'(RESP_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                lat_d = lat_q - 8'd1;
                if (lat_d == 8'd0) state_d = RESP;
            end
            RESP: begin
                if (l15_req_i.l15_req_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode and memory access happen in the accept cycle; results are latched for the return.
    always_comb begin
        offset   = l15_req_i.l15_address - BASE_ADDR;
        in_range = (l15_req_i.l15_address >= BASE_ADDR) && ((offset >> 3) < 40'(MEM_WORDS));
        idx      = offset[AW+2:3];
        nbytes   = 4'd1 << l15_req_i.l15_size[1:0];
        aligned  = !l15_req_i.l15_size[2] &&
                   ((l15_req_i.l15_address[2:0] & 3'(nbytes - 4'd1)) == 3'd0);
        byte_en  = 8'(((9'd1 << nbytes) - 9'd1) << l15_req_i.l15_address[2:0]);
        rtype_d  = L15_LOAD_RET;
        err_d    = 2'b00;
        atomic_d = 1'b0;
        do_write = 1'b0;
        d0_d     = '0;
        d1_d     = '0;
        d2_d     = '0;
        d3_d     = '0;
        case (l15_req_i.l15_rqtype)
            STORE_RQ: begin
                rtype_d = L15_ST_ACK;
                if (!in_range)     err_d    = 2'b10;
                else if (!aligned) err_d    = 2'b01;
                else               do_write = accept;
            end
            IMISS_RQ: begin
                rtype_d = L15_IFILL_RET;
                if (in_range) begin
                    d0_d = mem[{idx[AW-1:2], 2'd0}];
                    d1_d = mem[{idx[AW-1:2], 2'd1}];
                    d2_d = mem[{idx[AW-1:2], 2'd2}];
                    d3_d = mem[{idx[AW-1:2], 2'd3}];
                end else begin
                    err_d = 2'b10;
                end
            end
            ATOMIC_RQ: begin
                rtype_d  = L15_ATOMIC_RET;
                atomic_d = 1'b1;
                err_d    = 2'b11;
            end
            default: begin
                if (in_range) begin
                    d0_d = mem[{idx[AW-1:1], 1'b0}];
                    d1_d = mem[{idx[AW-1:1], 1'b1}];
                end else begin
                    err_d = 2'b10;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            req_cnt_o <= '0;
            rtype_q   <= L15_LOAD_RET;
            err_q     <= '0;
            atomic_q  <= 1'b0;
            nc_q      <= 1'b0;
            tid_q     <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (accept) begin
                req_cnt_o <= req_cnt_o + 32'd1;
                rtype_q   <= rtype_d;
                err_q     <= err_d;
                atomic_q  <= atomic_d;
                nc_q      <= l15_req_i.l15_nc;
                tid_q     <= l15_req_i.l15_threadid;
                d0_q      <= d0_d;
                d1_q      <= d1_d;
                d2_q      <= d2_d;
                d3_q      <= d3_d;
            end
        end
    end

    // Backing store is deliberately not reset so stores survive a mid-operation reset.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[idx][8*b +: 8] <= l15_req_i.l15_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        l15_rtrn_o                  = '0;
        l15_rtrn_o.l15_ack          = accept;
        l15_rtrn_o.l15_header_ack   = accept;
        l15_rtrn_o.l15_val          = (state_q == RESP);
        l15_rtrn_o.l15_returntype   = rtype_q;
        l15_rtrn_o.l15_error        = err_q;
        l15_rtrn_o.l15_noncacheable = nc_q;
        l15_rtrn_o.l15_atomic       = atomic_q;
        l15_rtrn_o.l15_threadid     = tid_q;
        l15_rtrn_o.l15_data_0       = d0_q;
        l15_rtrn_o.l15_data_1       = d1_q;
        l15_rtrn_o.l15_data_2       = d2_q;
        l15_rtrn_o.l15_data_3       = d3_q;
    end

    assign busy_o = (state_q != IDLE);
endmodule
